// File: rtl/i2s_tx.sv
// I2S (Philips) transmitter: a small input FIFO feeds a 2*SAMPLE_W-bit shifter, and each mono sample is sent on both channels.
// Optional I2S_TX_HOLD_EN: on underrun, repeat the last popped word instead of sending silence.
module i2s_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SAMPLE_W-1:0]              s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             bclk,
    output logic                             lrclk,
    output logic                             sdata,
    output logic                             underrun
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SLOTS  = 2 * SAMPLE_W;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int SH_W   = 2 * SAMPLE_W;

    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_ready;
    logic [DIV_W-1:0]    r_div;
    logic [SLOT_W-1:0]   r_slot;
    logic                r_bclk;
    logic                r_lrclk;
    logic                r_sdata;
    logic                r_underrun;
    logic [SH_W-1:0]     r_shift;
`ifdef I2S_TX_HOLD_EN
    logic [SAMPLE_W-1:0] r_last;
`endif

    logic                w_push;
    logic                w_tick;
    logic                w_fall;
    logic                w_load;
    logic                w_pop;
    logic [SAMPLE_W-1:0] w_head;
    logic [SLOT_W-1:0]   w_slot_next;
    logic [LVL_W-1:0]    w_level_next;
    logic [SH_W-1:0]     w_shift_next;

    assign w_push      = s_valid && r_ready;
    assign w_tick      = (r_div == DIV_W'(BCLK_DIV - 1));
    assign w_fall      = w_tick && r_bclk;
    // The load happens on the falling edge that enters slot 1 (one-bclk I2S delay).
    assign w_load      = w_fall && (r_slot == '0);
    assign w_pop       = w_load && (r_level != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_slot_next = (r_slot == SLOT_W'(SLOTS - 1)) ? '0 : r_slot + 1'b1;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    always_comb begin
        w_shift_next = r_shift;
        if (w_load) begin
            if (w_pop) begin
                w_shift_next = {w_head, w_head};
            end else begin
`ifdef I2S_TX_HOLD_EN
                w_shift_next = {r_last, r_last};
`else
                w_shift_next = '0;
`endif
            end
        end else if (w_fall) begin
            w_shift_next = {r_shift[SH_W-2:0], 1'b0};
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ready    <= 1'b0;
            r_div      <= '0;
            r_slot     <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_shift    <= '0;
`ifdef I2S_TX_HOLD_EN
            r_last     <= '0;
`endif
        end else begin
            r_level    <= w_level_next;
            r_ready    <= (w_level_next != LVL_W'(FIFO_DEPTH));
            r_underrun <= w_load && !w_pop;
            r_shift    <= w_shift_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_bclk <= ~r_bclk;
            end
            // Slot, word select and data all advance together on falling bclk.
            if (w_fall) begin
                r_slot  <= w_slot_next;
                r_lrclk <= (w_slot_next >= SLOT_W'(SAMPLE_W));
                r_sdata <= w_shift_next[SH_W-1];
            end
`ifdef I2S_TX_HOLD_EN
            if (w_pop) begin
                r_last <= w_head;
            end
`endif
        end
    end

    assign s_ready    = r_ready;
    assign fifo_level = r_level;
    assign bclk       = r_bclk;
    assign lrclk      = r_lrclk;
    assign sdata      = r_sdata;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx (SAMPLE_W=16, BCLK_DIV=2, FIFO_DEPTH=4): accepted words feed a queue model,
// each frame load pushes the expected word, and the serial monitor pops and compares when the frame completes.
module tb_i2s_tx;

    localparam int FRAME = 128;
`ifdef I2S_TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [2:0]  fifo_level;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tim_err = 0;
    int und_cnt = 0;
    int frames = 0;

    logic [15:0] mq[$];
    logic [16:0] fq[$];
    logic [15:0] last_w = '0;

    logic [15:0] m_left = '0;
    logic [15:0] m_right = '0;
    logic [15:0] m_exp;
    logic        m_prev_sd = 1'b0;
    logic        m_und_exp;
    int          m_slot;
    logic        m_eb;
    logic        m_el;

    i2s_tx #(
        .SAMPLE_W  (16),
        .BCLK_DIV  (2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .fifo_level(fifo_level),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // Edge counter and queue model: cyc is the number of edges since reset release.
    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0;
            mq.delete();
            fq.delete();
            last_w <= '0;
        end else begin
            cyc <= cyc + 1;
            if ((cyc + 1) % FRAME == 4) begin
                if (mq.size() > 0) begin
                    fq.push_back({1'b0, mq[0]});
                    last_w <= mq[0];
                    mq.delete(0);
                end else begin
                    fq.push_back({1'b1, HOLD ? last_w : 16'h0000});
                end
            end
            if (s_valid && s_ready) begin
                mq.push_back(s_data);
            end
        end
    end

    // Serial monitor: sampled on the falling clk edge, mid-slot for data.
    always @(negedge clk) begin
        if (cyc == 0) begin
            m_left = '0;
            m_right = '0;
            tim_err = 0;
            m_prev_sd = 1'b0;
        end else begin
            m_slot = (cyc / 4) % 32;
            m_eb = ((cyc / 2) % 2) == 1;
            m_el = (m_slot >= 16);
            if (bclk !== m_eb || lrclk !== m_el) tim_err++;
            if (sdata !== m_prev_sd && (cyc % 4) != 0) tim_err++;
            m_prev_sd = sdata;
            if (cyc % FRAME == 4) begin
                m_und_exp = (fq.size() > 0) ? fq[fq.size()-1][16] : 1'b0;
                total++;
                if (underrun !== m_und_exp) begin
                    bad++;
                    $display("FAIL underrun_at_load cyc=%0d got=%b exp=%b", cyc, underrun, m_und_exp);
                end
                if (underrun === 1'b1) und_cnt++;
            end else if (underrun !== 1'b0) begin
                tim_err++;
            end
            if (cyc % 4 == 2) begin
                if (m_slot >= 1 && m_slot <= 16) begin
                    m_left = {m_left[14:0], sdata};
                end else if (m_slot >= 17) begin
                    m_right = {m_right[14:0], sdata};
                end else if (cyc < FRAME) begin
                    total++;
                    if (sdata !== 1'b0) begin
                        bad++;
                        $display("FAIL first_slot0 got=%b exp=0", sdata);
                    end
                end else begin
                    m_right = {m_right[14:0], sdata};
                    total++;
                    if (fq.size() == 0) begin
                        bad++;
                        $display("FAIL frame_missing cyc=%0d got L=%h R=%h exp=none", cyc, m_left, m_right);
                    end else begin
                        m_exp = fq[0][15:0];
                        fq.delete(0);
                        frames++;
                        if (m_left !== m_exp || m_right !== m_exp) begin
                            bad++;
                            $display("FAIL frame_data cyc=%0d got L=%h R=%h exp=%h", cyc, m_left, m_right, m_exp);
                        end
                    end
                    total++;
                    if (tim_err !== 0) begin
                        bad++;
                        $display("FAIL frame_timing cyc=%0d got errs=%0d exp=0", cyc, tim_err);
                    end
                    tim_err = 0;
                    m_left = '0;
                    m_right = '0;
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        for (int k = 0; k < 5000 && cyc < t; k++) @(negedge clk);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        und_cnt = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push_word(input logic [15:0] w, output int acc_edge);
        bit a;
        bit done;
        done = 1'b0;
        acc_edge = -1;
        s_data = w;
        s_valid = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            a = s_ready;
            @(negedge clk);
            if (a) begin
                done = 1'b1;
                acc_edge = cyc;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL push_timeout word=%h got=stalled exp=accepted", w);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bclk, lrclk, sdata, underrun, s_ready, fifo_level} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {bclk, lrclk, sdata, underrun, s_ready, fifo_level});
        end
        rst = 1'b0;
        @(negedge clk);
        und_cnt = 0;
        total++;
        if (s_ready !== 1'b1 || fifo_level !== 3'd0 || bclk !== 1'b0) begin
            bad++;
            $display("FAIL post_release got ready=%b lvl=%0d bclk=%b exp ready=1 lvl=0 bclk=0", s_ready, fifo_level, bclk);
        end
    endtask

    task automatic test_idle();
        wait_cyc(300);
        total++;
        if (und_cnt !== 3) begin
            bad++;
            $display("FAIL idle_underruns got=%0d exp=3", und_cnt);
        end
    endtask

    task automatic test_single();
        int e;
        do_reset();
        push_word(16'h8001, e);
        s_valid = 1'b0;
        total++;
        if (fifo_level !== 3'd1) begin
            bad++;
            $display("FAIL single_level got=%0d exp=1", fifo_level);
        end
        wait_cyc(128);
        total++;
        if (und_cnt !== 0) begin
            bad++;
            $display("FAIL single_no_underrun got=%0d exp=0", und_cnt);
        end
        wait_cyc(140);
    endtask

    task automatic test_back_to_back();
        int e;
        int f0;
        logic [15:0] words [4];
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h7FFF; words[3] = 16'h0001;
        do_reset();
        f0 = frames;
        wait_cyc(10);
        for (int i = 0; i < 4; i++) push_word(words[i], e);
        s_valid = 1'b0;
        total++;
        if (s_ready !== 1'b0 || fifo_level !== 3'd4) begin
            bad++;
            $display("FAIL b2b_full got ready=%b lvl=%0d exp ready=0 lvl=4", s_ready, fifo_level);
        end
        wait_cyc(133);
        total++;
        if (fifo_level !== 3'd3 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_level1 got lvl=%0d ready=%b exp lvl=3 ready=1", fifo_level, s_ready);
        end
        wait_cyc(261);
        total++;
        if (fifo_level !== 3'd2) begin
            bad++;
            $display("FAIL b2b_level2 got=%0d exp=2", fifo_level);
        end
        wait_cyc(660);
        total++;
        if (frames - f0 !== 5) begin
            bad++;
            $display("FAIL b2b_frames got=%0d exp=5", frames - f0);
        end
    endtask

    task automatic test_hold_valid();
        int e [5];
        int f0;
        do_reset();
        f0 = frames;
        wait_cyc(10);
        for (int i = 0; i < 5; i++) push_word(16'h1111 * 16'(i + 1), e[i]);
        s_valid = 1'b0;
        total++;
        if (e[3] !== 14) begin
            bad++;
            $display("FAIL hold_fourth_edge got=%0d exp=14", e[3]);
        end
        total++;
        if (e[4] !== 133) begin
            bad++;
            $display("FAIL hold_fifth_edge got=%0d exp=133", e[4]);
        end
        wait_cyc(780);
        total++;
        if (frames - f0 !== 6) begin
            bad++;
            $display("FAIL hold_frames got=%0d exp=6", frames - f0);
        end
    endtask

    task automatic test_starve();
        int e;
        do_reset();
        push_word(16'h00FF, e);
        s_valid = 1'b0;
        wait_cyc(270);
        total++;
        if (und_cnt !== 2) begin
            bad++;
            $display("FAIL starve_underruns got=%0d exp=2", und_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        do_reset();
        wait_cyc(10);
        push_word(16'hC3A5, e);
        push_word(16'h5A3C, e);
        s_valid = 1'b0;
        wait_cyc(40);
        total++;
        if (fifo_level !== 3'd2) begin
            bad++;
            $display("FAIL mid_level_before got=%0d exp=2", fifo_level);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bclk, lrclk, sdata, s_ready, fifo_level} !== 7'h00) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%b exp=0", {bclk, lrclk, sdata, s_ready, fifo_level});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        und_cnt = 0;
        wait_cyc(140);
        total++;
        if (und_cnt !== 2 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL mid_restart got und=%0d lvl=%0d exp und=2 lvl=0", und_cnt, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_hold_valid();
        test_starve();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serial audio transmitter at the output end of the audio chain: accepts signed 16-bit parallel samples (e.g. from the preprocessor's audio_out) via valid/ready.
- Buffers samples in a small FIFO and serializes them as standard I2S (Philips) frames.
- Each mono sample is sent on both left and right channels.
- Generates its own bit clock and word-select from clk.

Parameters:
- SAMPLE_W, 16, sample width in bits; frame is 2*SAMPLE_W slots.
- BCLK_DIV, 4, clk cycles per bclk half-period (>=1); one bclk period = 2*BCLK_DIV clk.
- FIFO_DEPTH, 4, input FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- s_data  input  SAMPLE_W  signed sample to transmit.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept; registered, equals !full.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- bclk  output  1  I2S bit clock, registered.
- lrclk  output  1  I2S word select (0 = left, 1 = right), registered.
- sdata  output  1  I2S serial data, MSB first, registered.
- underrun  output  1  one-clk pulse when a word load finds the FIFO empty.

Behaviour:
- Reset (sync): bclk=0, lrclk=0, sdata=0, underrun=0, s_ready=0, fifo_level=0, FIFO empty, div counter=0, slot=0, shift reg=0. s_ready rises 1 cycle after rst deasserts.
- Divider: div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps and bclk toggles. bclk 1->0 transition = slot boundary; slot counter (0..2*SAMPLE_W-1) increments, wrapping to 0.
- Data changes only on falling bclk; the receiver samples on rising bclk.
- Slot map (SAMPLE_W=16):
  - lrclk=0 in slots 0..15, 1 in slots 16..31.
  - Left MSB..LSB in slots 1..16; right MSB..LSB in slots 17..31, then slot 0 of the next frame (one-bclk I2S delay).
- Load: on the boundary entering slot 1:
  - FIFO non-empty: pop head word W; shift reg <= {W,W}.
  - FIFO empty: shift reg <= 0 and underrun=1 for that clk.
- Other boundaries: shift reg shifts left by 1, zero fill. sdata = shift reg MSB, updated on the same clk as bclk falls.
- First frame after reset: slot 0 outputs 0; first load at clk 2*BCLK_DIV after reset release. Frame period = 4*SAMPLE_W*BCLK_DIV clk.
- FIFO: push when s_valid && s_ready. Full: s_ready=0 (registered), a simultaneous pop does not allow a push that cycle.
- Empty FIFO with push and load in the same clk: pushed word is not visible to the load; underrun fires; word stays queued (level=1).
- fifo_level updates 1 clk after push/pop; push+pop same clk leaves it unchanged.
- rst mid-frame: all state returns to reset values next clk; queued samples are discarded; bclk/lrclk/sdata drop to 0 immediately.

Optional Feature:
- Macro I2S_TX_HOLD_EN.
- Defined: on underrun, shift reg reloads {L,L}, where L is the last successfully popped word (0 if none since reset). underrun pulse still asserted.
- Undefined: underrun transmits silence (zeros), as above.

Test Plan (SAMPLE_W=16, BCLK_DIV=2, FIFO_DEPTH=4; frame=128 clk):
- Reset then idle, no s_valid -> bclk toggles every 2 clk; lrclk 0 for slots 0-15, 1 for 16-31; sdata all 0; underrun pulses once per frame at clk 4, 132, 260...
- Push 0x8001 before clk 4 -> sdata=1 in slots 1, 16, 17; slot 0 of next frame=1; all other slots 0; no underrun in first frame.
- Push 0x1234, 0xABCD, 0x7FFF, 0x0001 back-to-back -> s_ready=0 after 4th; fifo_level 4 then decrements each frame; frames carry the words in order on both channels.
- Push 5 words with s_valid held -> 5th accepted only after the first load; no data loss or reorder.
- Push 0x00FF, then starve -> frame 1 carries 0x00FF; frame 2 is zero with an underrun pulse (macro off); frame 2 repeats 0x00FF with a pulse (I2S_TX_HOLD_EN).
- Assert rst at slot 10 with 2 queued -> next clk: bclk=lrclk=sdata=0, fifo_level=0, s_ready=0; after release, timing restarts as at power-up.
